dram_model: RTL and testbench



---
 rtl/dram_model_if.sv | 16 +
 rtl/dram_model.sv | 105 ++++++++++
 tb/tb_dram_model.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/dram_model_if.sv
// Command bus into the DRAM model and read-return bus back out.
// The wrapper (or a bench) drives the master side; the model implements the slave side.
interface dram_model_if;
  logic        CSn;
  logic        RASn;
  logic        CASn;
  logic [3:0]  WEn;
  logic [10:0] A;
  logic [31:0] D;
  logic [31:0] Q;
  logic        VALID;
  logic        ERR;

  modport master (output CSn, RASn, CASn, WEn, A, D, input Q, VALID, ERR);
  modport slave  (input CSn, RASn, CASn, WEn, A, D, output Q, VALID, ERR);
endinterface

// File: rtl/dram_model.sv
// Single-bank DRAM device model: ACT/PRE/READ/WRITE decode, tRCD/tRP checks, sticky ERR.
// Read latency CAS_LAT cycles through a {valid,data} shift register; no backpressure.
module dram_model #(
  parameter int ROW_BITS = 11,
  parameter int COL_BITS = 10,
  parameter int T_RCD    = 4,
  parameter int T_RP     = 4,
  parameter int CAS_LAT  = 5
) (
  input logic         ACLK,
  input logic         ARESETn,
  dram_model_if.slave cmd_if
);

  localparam int AW    = ROW_BITS + COL_BITS;
  localparam int DEPTH = 1 << AW;
  localparam int CNT_W = 8;

  typedef enum logic {ROW_CLOSED, ROW_OPEN} row_state_e;

  row_state_e          row_q, row_d;
  logic [ROW_BITS-1:0] open_row_q, open_row_d;
  logic [CNT_W-1:0]    trcd_q, trcd_d;
  logic [CNT_W-1:0]    trp_q, trp_d;
  logic                err_q, err_d;
  logic [CAS_LAT-1:0]  vld_q;
  logic [31:0]         dat_q [CAS_LAT];
  logic [31:0]         mem [DEPTH];

  logic          is_act, is_pre, is_rd, is_wr;
  logic          act_ok, col_ok, rd_ok, wr_ok, bad_cmd;
  logic [AW-1:0] mem_addr;

  assign is_act = !cmd_if.CSn && !cmd_if.RASn && cmd_if.CASn && (cmd_if.WEn == 4'hF);
  assign is_pre = !cmd_if.CSn && !cmd_if.RASn && cmd_if.CASn && (cmd_if.WEn == 4'h0);
  assign is_rd  = !cmd_if.CSn && cmd_if.RASn && !cmd_if.CASn && (cmd_if.WEn == 4'hF);
  assign is_wr  = !cmd_if.CSn && cmd_if.RASn && !cmd_if.CASn && (cmd_if.WEn != 4'hF);

  assign act_ok  = is_act && (row_q == ROW_CLOSED) && (trp_q == '0);
  assign col_ok  = (row_q == ROW_OPEN) && (trcd_q == '0);
  assign rd_ok   = is_rd && col_ok;
  assign wr_ok   = is_wr && col_ok;
  assign bad_cmd = (is_act && !act_ok) || ((is_rd || is_wr) && !col_ok);

  assign mem_addr = {open_row_q, cmd_if.A[COL_BITS-1:0]};

  // Counters load one less than the parameter: the command edge itself counts as
  // the first elapsed cycle, so the follow-up becomes legal exactly T cycles later.
  always_comb begin
    row_d      = row_q;
    open_row_d = open_row_q;
    trcd_d     = (trcd_q != '0) ? trcd_q - 1'b1 : '0;
    trp_d      = (trp_q  != '0) ? trp_q  - 1'b1 : '0;
    err_d      = err_q | bad_cmd;
    if (act_ok) begin
      row_d      = ROW_OPEN;
      open_row_d = cmd_if.A[ROW_BITS-1:0];
      trcd_d     = CNT_W'(T_RCD - 1);
    end else if (is_pre) begin
      row_d = ROW_CLOSED;
      trp_d = CNT_W'(T_RP - 1);
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      row_q      <= ROW_CLOSED;
      open_row_q <= '0;
      trcd_q     <= '0;
      trp_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      row_q      <= row_d;
      open_row_q <= open_row_d;
      trcd_q     <= trcd_d;
      trp_q      <= trp_d;
      err_q      <= err_d;
    end
  end

  // Data is zeroed in empty slots so Q reads 0 whenever VALID is low.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      vld_q <= '0;
      for (int i = 0; i < CAS_LAT; i++) dat_q[i] <= '0;
    end else begin
      vld_q <= {vld_q[CAS_LAT-2:0], rd_ok};
      for (int i = 1; i < CAS_LAT; i++) dat_q[i] <= dat_q[i-1];
      dat_q[0] <= rd_ok ? mem[mem_addr] : 32'h0;
    end
  end

  always_ff @(posedge ACLK) begin
    if (wr_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (!cmd_if.WEn[b]) mem[mem_addr][8*b +: 8] <= cmd_if.D[8*b +: 8];
      end
    end
  end

  assign cmd_if.Q     = dat_q[CAS_LAT-1];
  assign cmd_if.VALID = vld_q[CAS_LAT-1];
  assign cmd_if.ERR   = err_q;

endmodule

// File: tb/tb_dram_model.sv
// Directed bench for dram_model: a per-cycle vector table plus hand-written timing/reset sequences.
module tb_dram_model;

  logic ACLK;
  logic ARESETn;
  dram_model_if bus();

  dram_model dut (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .cmd_if  (bus)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int passed = 0;
  int total  = 0;

  typedef struct {
    string       name;
    logic [2:0]  crc;    // {CSn, RASn, CASn}
    logic [3:0]  wen;
    logic [10:0] a;
    logic [31:0] d;
    logic        exp_vld;
    logic [31:0] exp_q;
    logic        exp_err;
  } vec_t;

  vec_t tbl [24];

  function automatic vec_t mk(string n, logic [2:0] crc, logic [3:0] wen, logic [10:0] a,
                              logic [31:0] d, logic ev, logic [31:0] eq, logic ee);
    vec_t v;
    v.name = n; v.crc = crc; v.wen = wen; v.a = a; v.d = d;
    v.exp_vld = ev; v.exp_q = eq; v.exp_err = ee;
    return v;
  endfunction

  task automatic check(string n, logic v, logic [31:0] q, logic e);
    total++;
    if (bus.VALID !== v || bus.Q !== q || bus.ERR !== e)
      $display("FAIL %s: got valid=%0b q=%h err=%0b, want valid=%0b q=%h err=%0b",
               n, bus.VALID, bus.Q, bus.ERR, v, q, e);
    else
      passed++;
  endtask

  task automatic drive(logic [2:0] crc, logic [3:0] wen, logic [10:0] a, logic [31:0] d);
    bus.CSn  = crc[2];
    bus.RASn = crc[1];
    bus.CASn = crc[0];
    bus.WEn  = wen;
    bus.A    = a;
    bus.D    = d;
  endtask

  task automatic send(logic [2:0] crc, logic [3:0] wen, logic [10:0] a, logic [31:0] d);
    drive(crc, wen, a, d);
    @(posedge ACLK);
    #1;
  endtask

  task automatic nop();
    send(3'b111, 4'hF, 11'h0, 32'h0);
  endtask

  task automatic do_reset();
    drive(3'b111, 4'hF, 11'h0, 32'h0);
    ARESETn = 1'b0;
    #3;
    @(posedge ACLK);
    #1;
    ARESETn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1, "timeout");
  end

  initial begin
    ARESETn = 1'b1;
    drive(3'b111, 4'hF, 11'h0, 32'h0);
    #2 ARESETn = 1'b0;
    #1 check("reset_async", 1'b0, 32'h0, 1'b0);
    @(posedge ACLK);
    #1 ARESETn = 1'b1;
    check("reset_release", 1'b0, 32'h0, 1'b0);

    // Outputs expected after each command edge.
    tbl[0]  = mk("act_r5",     3'b001, 4'hF, 11'h005, 32'h0,        1'b0, 32'h0,        1'b0);
    tbl[1]  = mk("nop1",       3'b111, 4'hF, 11'h000, 32'h0,        1'b0, 32'h0,        1'b0);
    tbl[2]  = mk("nop2",       3'b111, 4'hF, 11'h000, 32'h0,        1'b0, 32'h0,        1'b0);
    tbl[3]  = mk("nop3",       3'b111, 4'hF, 11'h000, 32'h0,        1'b0, 32'h0,        1'b0);
    tbl[4]  = mk("wr_beef",    3'b010, 4'h0, 11'h010, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0);
    tbl[5]  = mk("rd_beef",    3'b010, 4'hF, 11'h010, 32'h0,        1'b0, 32'h0,        1'b0);
    tbl[6]  = mk("wr_byte0",   3'b010, 4'hE, 11'h010, 32'h000000AA, 1'b0, 32'h0,        1'b0);
    tbl[7]  = mk("rd_byte0",   3'b010, 4'hF, 11'h010, 32'h0,        1'b0, 32'h0,        1'b0);
    tbl[8]  = mk("wr_c20",     3'b010, 4'h0, 11'h020, 32'h1,        1'b0, 32'h0,        1'b0);
    tbl[9]  = mk("ret_beef",   3'b010, 4'h0, 11'h021, 32'h2,        1'b1, 32'hDEADBEEF, 1'b0);
    tbl[10] = mk("wr_c22",     3'b010, 4'h0, 11'h022, 32'h3,        1'b0, 32'h0,        1'b0);
    tbl[11] = mk("ret_beaa",   3'b010, 4'h0, 11'h023, 32'h4,        1'b1, 32'hDEADBEAA, 1'b0);
    tbl[12] = mk("rd_c20",     3'b010, 4'hF, 11'h020, 32'h0,        1'b0, 32'h0,        1'b0);
    tbl[13] = mk("rd_c21",     3'b010, 4'hF, 11'h021, 32'h0,        1'b0, 32'h0,        1'b0);
    tbl[14] = mk("rd_c22",     3'b010, 4'hF, 11'h022, 32'h0,        1'b0, 32'h0,        1'b0);
    tbl[15] = mk("rd_c23",     3'b010, 4'hF, 11'h023, 32'h0,        1'b0, 32'h0,        1'b0);
    tbl[16] = mk("pre_burst1", 3'b001, 4'h0, 11'h000, 32'h0,        1'b1, 32'h1,        1'b0);
    tbl[17] = mk("burst2",     3'b111, 4'hF, 11'h000, 32'h0,        1'b1, 32'h2,        1'b0);
    tbl[18] = mk("burst3",     3'b111, 4'hF, 11'h000, 32'h0,        1'b1, 32'h3,        1'b0);
    tbl[19] = mk("burst4",     3'b111, 4'hF, 11'h000, 32'h0,        1'b1, 32'h4,        1'b0);
    tbl[20] = mk("act_trp_ok", 3'b001, 4'hF, 11'h006, 32'h0,        1'b0, 32'h0,        1'b0);
    tbl[21] = mk("ras_cas_nop",3'b000, 4'hF, 11'h000, 32'h0,        1'b0, 32'h0,        1'b0);
    tbl[22] = mk("csn_hi_nop", 3'b110, 4'hF, 11'h010, 32'h0,        1'b0, 32'h0,        1'b0);
    tbl[23] = mk("idle",       3'b111, 4'hF, 11'h000, 32'h0,        1'b0, 32'h0,        1'b0);

    for (int i = 0; i < 24; i++) begin
      send(tbl[i].crc, tbl[i].wen, tbl[i].a, tbl[i].d);
      check(tbl[i].name, tbl[i].exp_vld, tbl[i].exp_q, tbl[i].exp_err);
    end

    // READ two cycles after ACT: flagged, never returns.
    do_reset();
    send(3'b001, 4'hF, 11'h005, 32'h0);
    check("a_act", 1'b0, 32'h0, 1'b0);
    nop();
    check("a_wait", 1'b0, 32'h0, 1'b0);
    send(3'b010, 4'hF, 11'h010, 32'h0);
    check("a_rd_early", 1'b0, 32'h0, 1'b1);
    for (int i = 0; i < 6; i++) begin
      nop();
      check("a_no_valid", 1'b0, 32'h0, 1'b1);
    end

    // Second ACT while the row is open.
    do_reset();
    send(3'b001, 4'hF, 11'h005, 32'h0);
    for (int i = 0; i < 4; i++) nop();
    check("b_open_ok", 1'b0, 32'h0, 1'b0);
    send(3'b001, 4'hF, 11'h007, 32'h0);
    check("b_act_open", 1'b0, 32'h0, 1'b1);

    // ACT three cycles after PRE is early.
    do_reset();
    send(3'b001, 4'h0, 11'h000, 32'h0);
    nop();
    nop();
    send(3'b001, 4'hF, 11'h005, 32'h0);
    check("c_act_trp3", 1'b0, 32'h0, 1'b1);

    // Four cycles after PRE is accepted; memory survives reset.
    do_reset();
    send(3'b001, 4'h0, 11'h000, 32'h0);
    for (int i = 0; i < 3; i++) nop();
    send(3'b001, 4'hF, 11'h005, 32'h0);
    check("c_act_trp4", 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) nop();
    send(3'b010, 4'hF, 11'h010, 32'h0);
    check("c_rd_trcd4", 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) nop();
    check("c_lat_early", 1'b0, 32'h0, 1'b0);
    nop();
    check("c_mem_kept", 1'b1, 32'hDEADBEAA, 1'b0);

    // Sticky ERR, then reset with a read in flight.
    send(3'b001, 4'hF, 11'h005, 32'h0);
    check("d_act_open", 1'b0, 32'h0, 1'b1);
    send(3'b010, 4'hF, 11'h020, 32'h0);
    check("d_err_sticky", 1'b0, 32'h0, 1'b1);
    nop();
    #2 ARESETn = 1'b0;
    #1 check("d_rst_async", 1'b0, 32'h0, 1'b0);
    @(posedge ACLK);
    #1 ARESETn = 1'b1;
    for (int i = 0; i < 8; i++) begin
      nop();
      check("d_no_ghost", 1'b0, 32'h0, 1'b0);
    end
    send(3'b010, 4'hF, 11'h020, 32'h0);
    check("d_row_closed", 1'b0, 32'h0, 1'b1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
